// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
//   Types and constants shared by the vending machine controller and its
//   payout back end.
//     payout_state_t : payout sequencer states
//     payout_cw()    : width of a counter that must hold 0..depth
//     COIN_*_VALUE   : coin denominations used by vendingMachine
// -----------------------------------------------------------------------------
package vend_pkg;

    localparam int COIN_5_VALUE  = 5;
    localparam int COIN_10_VALUE = 10;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_VEND_RUN       = 3'd1,
        ST_VEND_WAIT_HOME = 3'd2,
        ST_CHANGE_KICK    = 3'd3,
        ST_CHANGE_WAIT    = 3'd4,
        ST_FAULT          = 3'd5
    } payout_state_t;

    // Width needed to represent every value from 0 up to and including depth.
    function automatic int payout_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/payout_req_counter.sv
// -----------------------------------------------------------------------------
// payout_req_counter
//   Saturating up/down counter of outstanding payout requests with a sticky
//   overflow flag. An increment arriving while the count is at QDEPTH is
//   dropped and sets the flag; only reset clears it. Increment and decrement
//   in the same cycle cancel (nothing is dropped).
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   i_inc       in   one new request this cycle
//   i_dec       in   one request serviced this cycle
//   o_count     out  outstanding requests (0..QDEPTH)
//   o_overflow  out  sticky: an increment was dropped at saturation
// -----------------------------------------------------------------------------
module payout_req_counter
    import vend_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int CW     = payout_cw(QDEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_overflow
);

    localparam logic [CW-1:0] COUNT_MAX = CW'(QDEPTH);

    logic [CW-1:0] r_count;
    logic          r_overflow;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    // NOTE: reset is synchronous (sampled only at the clock edge), so it lives
    // inside the edge-triggered block rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case ({i_inc, i_dec})
                2'b10: begin
                    if (r_count == COUNT_MAX) r_overflow <= 1'b1;
                    else                      r_count    <= r_count + 1'b1;
                end
                2'b01: begin
                    if (r_count != '0) r_count <= r_count - 1'b1;
                end
                default: ;  // idle, or inc and dec cancel
            endcase
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/vend_payout_ctrl.sv
// -----------------------------------------------------------------------------
// vend_payout_ctrl
//   Payout back end of the vending machine. Queues product (dispense) and
//   5-unit change (change_5) requests and sequences the vend motor and the
//   coin hopper against their home / exit sensors. Product is served before
//   change. All outputs are registered.
// Optional feature
//   PAYOUT_TIMEOUT_EN : when defined, a sensor wait longer than TIMEOUT_CYCLES
//   parks the block in FAULT (actuators off, fault=1, busy=1) until reset.
//   When undefined, sensor waits are unbounded and fault is tied low.
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high
//   dispense        in   1-cycle pulse: one product owed
//   change_5        in   1-cycle pulse: one 5-unit coin owed
//   motor_home      in   vend mechanism at home position (level)
//   coin_sensed     in   1-cycle pulse: hopper exit sensor saw a coin
//   motor_on        out  vend motor drive (level)
//   hopper_kick     out  1-cycle hopper release pulse
//   busy            out  sequencer not idle
//   overflow        out  sticky: a request was dropped at saturation
//   fault           out  sticky sensor timeout
//   pending_items   out  outstanding product requests
//   pending_change  out  outstanding change requests
// -----------------------------------------------------------------------------
module vend_payout_ctrl
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int QDEPTH         = 4,
    parameter int CW             = payout_cw(QDEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dispense,
    input  logic          change_5,
    input  logic          motor_home,
    input  logic          coin_sensed,
    output logic          motor_on,
    output logic          hopper_kick,
    output logic          busy,
    output logic          overflow,
    output logic          fault,
    output logic [CW-1:0] pending_items,
    output logic [CW-1:0] pending_change
);

    // One timer serves both the motor run length and the sensor timeout.
    localparam int TIMER_MAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
    localparam int TW        = $clog2(TIMER_MAX + 1);

    payout_state_t r_state;
    payout_state_t w_next_state;
    logic [TW-1:0] r_timer;
    logic          w_items_dec;
    logic          w_change_dec;
    logic          w_items_ovf;
    logic          w_change_ovf;
    logic          r_motor_on;
    logic          r_hopper_kick;
    logic          r_busy;

    payout_req_counter #(.QDEPTH(QDEPTH), .CW(CW)) u_items_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (dispense),
        .i_dec      (w_items_dec),
        .o_count    (pending_items),
        .o_overflow (w_items_ovf)
    );

    payout_req_counter #(.QDEPTH(QDEPTH), .CW(CW)) u_change_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (change_5),
        .i_dec      (w_change_dec),
        .o_count    (pending_change),
        .o_overflow (w_change_ovf)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_items_dec  = 1'b0;
        w_change_dec = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pending_items != '0)       w_next_state = ST_VEND_RUN;
                else if (pending_change != '0) w_next_state = ST_CHANGE_KICK;
            end
            ST_VEND_RUN: begin
                // motor_home is not examined until the motor has run its minimum time
                if (r_timer == TW'(MOTOR_CYCLES - 1)) w_next_state = ST_VEND_WAIT_HOME;
            end
            ST_VEND_WAIT_HOME: begin
                if (motor_home) begin
                    w_items_dec  = 1'b1;
                    w_next_state = ST_IDLE;
                end
`ifdef PAYOUT_TIMEOUT_EN
                else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_next_state = ST_FAULT;
                end
`endif
            end
            ST_CHANGE_KICK: begin
                w_next_state = ST_CHANGE_WAIT;
            end
            ST_CHANGE_WAIT: begin
                if (coin_sensed) begin
                    w_change_dec = 1'b1;
                    w_next_state = ST_IDLE;
                end
`ifdef PAYOUT_TIMEOUT_EN
                else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_next_state = ST_FAULT;
                end
`endif
            end
            ST_FAULT: begin
                w_next_state = ST_FAULT;  // left only through reset
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they switch on
    // the same edge as the state itself while staying glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_motor_on    <= 1'b0;
            r_hopper_kick <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_motor_on    <= (w_next_state == ST_VEND_RUN) || (w_next_state == ST_VEND_WAIT_HOME);
            r_hopper_kick <= (w_next_state == ST_CHANGE_KICK);
            r_busy        <= (w_next_state != ST_IDLE);
            // Timer measures cycles since entry into the current state.
            if (w_next_state != r_state)      r_timer <= '0;
            else if (r_timer != TW'(TIMER_MAX)) r_timer <= r_timer + 1'b1;
        end
    end

`ifdef PAYOUT_TIMEOUT_EN
    logic r_fault;

    always_ff @(posedge clk) begin
        if (reset) r_fault <= 1'b0;
        else       r_fault <= (w_next_state == ST_FAULT);
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign motor_on    = r_motor_on;
    assign hopper_kick = r_hopper_kick;
    assign busy        = r_busy;
    assign overflow    = w_items_ovf | w_change_ovf;

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_payout_ctrl
//   Self-checking bench for vend_payout_ctrl. Directed scenarios plus a
//   randomized run in which the bench plays the vend mechanism and the coin
//   hopper and keeps its own request ledger. Honors PAYOUT_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_vend_payout_ctrl;

    localparam int MOTOR_CYCLES   = 8;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int QDEPTH         = 4;
    localparam int CW             = 3;

    logic          clk = 1'b0;
    logic          reset, dispense, change_5, motor_home, coin_sensed;
    logic          motor_on, hopper_kick, busy, overflow, fault;
    logic [CW-1:0] pending_items, pending_change;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vend_payout_ctrl #(
        .MOTOR_CYCLES   (MOTOR_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .QDEPTH         (QDEPTH),
        .CW             (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dispense       (dispense),
        .change_5       (change_5),
        .motor_home     (motor_home),
        .coin_sensed    (coin_sensed),
        .motor_on       (motor_on),
        .hopper_kick    (hopper_kick),
        .busy           (busy),
        .overflow       (overflow),
        .fault          (fault),
        .pending_items  (pending_items),
        .pending_change (pending_change)
    );

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; dispense = 1'b0; change_5 = 1'b0; motor_home = 1'b0; coin_sensed = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dispense = 1'($urandom); change_5 = 1'($urandom);
            motor_home = 1'($urandom); coin_sensed = 1'($urandom);
            tick();
        end
        dispense = 1'b0; change_5 = 1'b0; motor_home = 1'b0; coin_sensed = 1'b0;
        reset = 1'b0;
        n_tests++; if (motor_on !== 1'b0) begin n_fail++; $display("FAIL reset_motor_on: got %b want 0", motor_on); end
        n_tests++; if (hopper_kick !== 1'b0) begin n_fail++; $display("FAIL reset_hopper_kick: got %b want 0", hopper_kick); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
        n_tests++; if (pending_items !== 3'd0) begin n_fail++; $display("FAIL reset_items: got %0d want 0", pending_items); end
        n_tests++; if (pending_change !== 3'd0) begin n_fail++; $display("FAIL reset_change: got %0d want 0", pending_change); end
    endtask

    task automatic test_single_vend();
        int hi, fall;
        do_reset();
        dispense = 1'b1; tick(); dispense = 1'b0;
        n_tests++; if (pending_items !== 3'd1) begin n_fail++; $display("FAIL vend_count_up: got %0d want 1", pending_items); end
        n_tests++; if (motor_on !== 1'b0) begin n_fail++; $display("FAIL vend_motor_latency: got %b want 0", motor_on); end
        hi = 0; fall = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) begin
                n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL vend_busy_rise: got %b want 1", busy); end
            end
            if (motor_on === 1'b1) hi++;
            else begin fall = c; break; end
            // motor_home becomes visible 5 edges after the wait state is entered
            if (c == MOTOR_CYCLES + 5) motor_home = 1'b1;
        end
        motor_home = 1'b0;
        n_tests++; if (fall == 0) begin n_fail++; $display("FAIL vend_done_timeout: got no motor fall want fall within 60 cycles"); end
        n_tests++; if (hi != MOTOR_CYCLES + 5) begin n_fail++; $display("FAIL vend_motor_width: got %0d want %0d", hi, MOTOR_CYCLES + 5); end
        n_tests++; if (pending_items !== 3'd0) begin n_fail++; $display("FAIL vend_count_down: got %0d want 0", pending_items); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL vend_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        int hi, fall;
        bit kick_in_vend;
        do_reset();
        dispense = 1'b1; change_5 = 1'b1; tick(); dispense = 1'b0; change_5 = 1'b0;
        n_tests++; if (pending_items !== 3'd1) begin n_fail++; $display("FAIL both_items: got %0d want 1", pending_items); end
        n_tests++; if (pending_change !== 3'd1) begin n_fail++; $display("FAIL both_change: got %0d want 1", pending_change); end
        motor_home = 1'b1;  // already home: only the minimum run plus one wait edge
        hi = 0; fall = 0; kick_in_vend = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (hopper_kick === 1'b1) kick_in_vend = 1'b1;
            if (motor_on === 1'b1) hi++;
            else begin fall = c; break; end
        end
        motor_home = 1'b0;
        n_tests++; if (hi != MOTOR_CYCLES + 1) begin n_fail++; $display("FAIL both_motor_width: got %0d want %0d", hi, MOTOR_CYCLES + 1); end
        n_tests++; if (kick_in_vend || hopper_kick !== 1'b0) begin n_fail++; $display("FAIL both_priority: got kick during vend=%0d want 0", kick_in_vend); end
        tick();
        n_tests++; if (hopper_kick !== 1'b1) begin n_fail++; $display("FAIL both_kick_rise: got %b want 1", hopper_kick); end
        tick();
        n_tests++; if (hopper_kick !== 1'b0) begin n_fail++; $display("FAIL both_kick_width: got %b want 0", hopper_kick); end
        n_tests++; if (pending_change !== 3'd1) begin n_fail++; $display("FAIL both_change_held: got %0d want 1", pending_change); end
        tick();
        coin_sensed = 1'b1; tick(); coin_sensed = 1'b0;
        n_tests++; if (pending_change !== 3'd0) begin n_fail++; $display("FAIL both_change_done: got %0d want 0", pending_change); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin dispense = 1'b1; tick(); end
        dispense = 1'b0;
        n_tests++; if (pending_items !== 3'd4) begin n_fail++; $display("FAIL sat_items: got %0d want 4", pending_items); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %b want 1", overflow); end
        for (int i = 0; i < 6; i++) begin change_5 = 1'b1; tick(); end
        change_5 = 1'b0;
        repeat (10) tick();
        n_tests++; if (pending_change !== 3'd4) begin n_fail++; $display("FAIL sat_change: got %0d want 4", pending_change); end
        n_tests++; if (pending_items !== 3'd4) begin n_fail++; $display("FAIL sat_items_hold: got %0d want 4", pending_items); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow_sticky: got %b want 1", overflow); end
        do_reset();
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat_overflow_reset: got %b want 0", overflow); end
    endtask

    task automatic test_timeout();
        do_reset();
        change_5 = 1'b1; tick(); change_5 = 1'b0;
        tick();
        n_tests++; if (hopper_kick !== 1'b1) begin n_fail++; $display("FAIL to_kick: got %b want 1", hopper_kick); end
        // wait state entered at the next edge; stop one edge short of the limit
        for (int c = 2; c <= TIMEOUT_CYCLES + 1; c++) tick();
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL to_fault_early: got %b want 0", fault); end
        tick();
`ifdef PAYOUT_TIMEOUT_EN
        n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL to_fault_set: got %b want 1", fault); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_fault_busy: got %b want 1", busy); end
        n_tests++; if (hopper_kick !== 1'b0) begin n_fail++; $display("FAIL to_fault_kick: got %b want 0", hopper_kick); end
        coin_sensed = 1'b1; tick(); coin_sensed = 1'b0;
        n_tests++; if (pending_change !== 3'd1) begin n_fail++; $display("FAIL to_fault_coin_ignored: got %0d want 1", pending_change); end
        dispense = 1'b1; tick(); dispense = 1'b0;
        repeat (3) tick();
        n_tests++; if (pending_items !== 3'd1) begin n_fail++; $display("FAIL to_fault_counts: got %0d want 1", pending_items); end
        n_tests++; if (motor_on !== 1'b0) begin n_fail++; $display("FAIL to_fault_motor: got %b want 0", motor_on); end
        n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL to_fault_sticky: got %b want 1", fault); end
`else
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL to_nofault: got %b want 0", fault); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_still_busy: got %b want 1", busy); end
        coin_sensed = 1'b1; tick(); coin_sensed = 1'b0;
        n_tests++; if (pending_change !== 3'd0) begin n_fail++; $display("FAIL to_late_coin: got %0d want 0", pending_change); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle_after_coin: got %b want 0", busy); end
`endif
    endtask

    task automatic test_reset_mid_vend();
        int hi, fall;
        do_reset();
        dispense = 1'b1; tick(); tick(); dispense = 1'b0;
        repeat (MOTOR_CYCLES + 3) tick();
        n_tests++; if (motor_on !== 1'b1) begin n_fail++; $display("FAIL midrst_motor_before: got %b want 1", motor_on); end
        n_tests++; if (pending_items !== 3'd2) begin n_fail++; $display("FAIL midrst_items_before: got %0d want 2", pending_items); end
        reset = 1'b1; tick(); reset = 1'b0;
        n_tests++; if (motor_on !== 1'b0) begin n_fail++; $display("FAIL midrst_motor_after: got %b want 0", motor_on); end
        n_tests++; if (pending_items !== 3'd0) begin n_fail++; $display("FAIL midrst_items_after: got %0d want 0", pending_items); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
        motor_home = 1'b1;
        dispense = 1'b1; tick(); dispense = 1'b0;
        hi = 0; fall = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (motor_on === 1'b1) hi++;
            else begin fall = c; break; end
        end
        motor_home = 1'b0;
        n_tests++; if (hi != MOTOR_CYCLES + 1) begin n_fail++; $display("FAIL midrst_revend_width: got %0d want %0d", hi, MOTOR_CYCLES + 1); end
        n_tests++; if (pending_items !== 3'd0) begin n_fail++; $display("FAIL midrst_revend_items: got %0d want 0", pending_items); end
    endtask

    // The bench acts as mechanism and hopper with random response delays and
    // keeps a request ledger: +1 per pulse (dropped when full), -1 for each
    // motor_home / coin_sensed it deliberately presents to a waiting service.
    task automatic test_random();
        int  m_items, m_change, hi, d, kick_age, cd;
        bit  m_ovf, home_now, coin_now, prev_kick, drained;
        do_reset();
        m_items = 0; m_change = 0; m_ovf = 1'b0;
        hi = 0; d = 1; kick_age = -1; cd = 1; prev_kick = 1'b0; drained = 1'b0;
        for (int c = 0; c < 600; c++) begin
            dispense = (c < 12) && ($urandom_range(0, 2) == 0);
            change_5 = (c < 12) && ($urandom_range(0, 2) == 0);
            home_now = (motor_on === 1'b1) && (hi == MOTOR_CYCLES + d);
            coin_now = (kick_age == cd);
            motor_home  = home_now;
            // stray coin pulses while vending must be ignored
            coin_sensed = coin_now || ((motor_on === 1'b1) && ($urandom_range(0, 3) == 0));
            if (dispense && !home_now && m_items == QDEPTH) m_ovf = 1'b1;
            else m_items = m_items + int'(dispense) - int'(home_now);
            if (change_5 && !coin_now && m_change == QDEPTH) m_ovf = 1'b1;
            else m_change = m_change + int'(change_5) - int'(coin_now);
            tick();
            n_tests++; if (pending_items !== CW'(m_items)) begin n_fail++; $display("FAIL rnd_items c=%0d: got %0d want %0d", c, pending_items, m_items); end
            n_tests++; if (pending_change !== CW'(m_change)) begin n_fail++; $display("FAIL rnd_change c=%0d: got %0d want %0d", c, pending_change, m_change); end
            n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow c=%0d: got %b want %b", c, overflow, m_ovf); end
            if (home_now) begin
                n_tests++; if (motor_on !== 1'b0) begin n_fail++; $display("FAIL rnd_motor_stop c=%0d: got %b want 0", c, motor_on); end
                hi = 0;
            end else if (motor_on === 1'b1) begin
                if (hi == 0) d = $urandom_range(1, 6);
                hi++;
            end else if (hi != 0) begin
                n_tests++; n_fail++; $display("FAIL rnd_motor_early c=%0d: got motor off after %0d want %0d", c, hi, MOTOR_CYCLES + d);
                hi = 0;
            end
            if (coin_now) kick_age = -1;
            else if (kick_age >= 0) kick_age++;
            if (hopper_kick === 1'b1) begin
                if (prev_kick) begin n_tests++; n_fail++; $display("FAIL rnd_kick_width c=%0d: got 2+ cycles want 1", c); end
                kick_age = 0; cd = $urandom_range(1, 5);
            end
            prev_kick = (hopper_kick === 1'b1);
            if (c >= 12 && m_items == 0 && m_change == 0 && hi == 0 && kick_age == -1) begin
                drained = 1'b1;
                break;
            end
        end
        dispense = 1'b0; change_5 = 1'b0; motor_home = 1'b0; coin_sensed = 1'b0;
        n_tests++; if (!drained) begin n_fail++; $display("FAIL rnd_drain_timeout: got items=%0d change=%0d want 0/0 within 600 cycles", m_items, m_change); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_busy_end: got %b want 0", busy); end
    endtask

    initial begin
        reset = 1'b1; dispense = 1'b0; change_5 = 1'b0; motor_home = 1'b0; coin_sensed = 1'b0;
        test_reset();
        test_single_vend();
        test_simultaneous();
        test_saturation();
        test_timeout();
        test_reset_mid_vend();
        for (int r = 0; r < 6; r++) test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
